// File: rtl/arb_rr_oht_if.sv
// Purpose: request/grant bundle between requesters and the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: level-held requests; a requester waits until its gnt bit is set.
interface arb_rr_oht_if #(
   parameter int WIDTH = 8
) ();
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] gnt;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic             expired;

   // requester side drives req, arbiter side drives the grant outputs
   modport master (output req, input gnt, gnt_vld, gnt_idx, expired);
   modport slave  (input req, output gnt, gnt_vld, gnt_idx, expired);
endinterface

// File: rtl/arb_rr_oht.sv
// Purpose: round-robin arbiter with a registered one-hot grant, plus its priority-to-one-hot trees.
// Latency: 1 cycle from request (or owner release) to grant; no idle cycle on handover.
// Backpressure: owner holds gnt while req stays high; ARB_RR_OHT_HOLD_LIMIT_EN caps the hold at HOLD_MAX cycles.

// Flat priority-to-one-hot: first set bit from the chosen end.
module pry2oht_base #(
   parameter int N              = 2,
   parameter     DIRECTION      = "LSB",
   parameter int IMPLEMENTATION = 0
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] oht,
   output logic         vld
);
   localparam bit         MSB = (DIRECTION == "MSB");
   localparam logic [N-1:0] ONE = 1;

   logic found;

   // pick the first requesting bit; the two's-complement form is only valid from the LSB end
   always_comb begin
      oht   = '0;
      found = 1'b0;
      vld   = |req;
      if (IMPLEMENTATION != 0 && !MSB) begin
         oht = req & (~req + ONE);
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!found && req[MSB ? N-1-k : k]) begin
               oht[MSB ? N-1-k : k] = 1'b1;
               found                = 1'b1;
            end
         end
      end
   end
endmodule

// Recursive tree: SPLIT groups each resolved locally, then the winning group chosen.
module pry2oht_tree #(
   parameter int WIDTH          = 8,
   parameter int SPLIT          = 2,
   parameter     DIRECTION      = "LSB",
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] oht,
   output logic             vld
);
   if (WIDTH <= SPLIT) begin : g_leaf
      pry2oht_base #(.N(WIDTH), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION))
         u_base (.req(req), .oht(oht), .vld(vld));
   end else begin : g_node
      localparam int SUB = WIDTH / SPLIT;
      logic [SPLIT-1:0] grp_vld;
      logic [SPLIT-1:0] grp_sel;
      logic [WIDTH-1:0] sub_oht;

      for (genvar g = 0; g < SPLIT; g++) begin : g_grp
         pry2oht_tree #(.WIDTH(SUB), .SPLIT(SPLIT), .DIRECTION(DIRECTION),
                        .IMPLEMENTATION(IMPLEMENTATION))
            u_sub (.req(req[g*SUB +: SUB]), .oht(sub_oht[g*SUB +: SUB]), .vld(grp_vld[g]));
         assign oht[g*SUB +: SUB] = sub_oht[g*SUB +: SUB] & {SUB{grp_sel[g]}};
      end

      pry2oht_base #(.N(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION))
         u_top (.req(grp_vld), .oht(grp_sel), .vld(vld));
   end
endmodule

module arb_rr_oht #(
   parameter int WIDTH          = 8,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0,
   parameter int HOLD_MAX       = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   arb_rr_oht_if.slave  bus
);
   localparam int IDX_W = $clog2(WIDTH);

   if (WIDTH < 2 || HOLD_MAX < 1) begin : g_param_chk
      $error("arb_rr_oht: WIDTH must be >= 2 and HOLD_MAX >= 1");
   end

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic             force_ho;
   logic             owner_req;
   logic [WIDTH-1:0] req_sel, msk, msk_oht, raw_oht, sel;
   logic             msk_vld, raw_vld;
   logic [IDX_W-1:0] sel_idx;

   assign owner_req = bus.req[idx_q];

`ifdef ARB_RR_OHT_HOLD_LIMIT_EN
   localparam int               CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q;
   logic             others;

   // owner has used its budget and someone else is waiting: evict it this edge
   always_comb begin
      others   = |(bus.req & ~gnt_q);
      force_ho = (state_q == ST_GRANT) && owner_req && (cnt_q == CNT_MAX) && others;
   end

   // hold counter restarts on every new owner and saturates at the limit
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_GRANT && owner_req && !force_ho)
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // counter and eviction pulse registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= force_ho;
      end
   end

   assign bus.expired = expired_q;
`else
   assign force_ho    = 1'b0;
   assign bus.expired = 1'b0;
`endif

   // candidates above the last owner get first pick; an evicted owner is not a candidate
   always_comb begin
      req_sel = force_ho ? (bus.req & ~gnt_q) : bus.req;
      for (int i = 0; i < WIDTH; i++)
         msk[i] = req_sel[i] & (i > int'(ptr_q));
   end

   pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION("LSB"), .IMPLEMENTATION(IMPLEMENTATION))
      u_msk (.req(msk), .oht(msk_oht), .vld(msk_vld));
   pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION("LSB"), .IMPLEMENTATION(IMPLEMENTATION))
      u_raw (.req(req_sel), .oht(raw_oht), .vld(raw_vld));

   // fall back to the unmasked pick to wrap around past WIDTH-1
   always_comb begin
      sel     = msk_vld ? msk_oht : raw_oht;
      sel_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (sel[i]) sel_idx = IDX_W'(i);
   end

   // grant FSM: hold while the owner requests, otherwise hand over or go idle
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (raw_vld) begin
               gnt_d   = sel;
               idx_d   = sel_idx;
               ptr_d   = sel_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (owner_req && !force_ho) begin
               gnt_d = gnt_q;
            end else if (raw_vld) begin
               gnt_d = sel;
               idx_d = sel_idx;
               ptr_d = sel_idx;
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      gnt_vld_d = |gnt_d;
   end

   // state registers; the pointer restarts at the top so requester 0 wins first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         idx_q     <= '0;
         ptr_q     <= IDX_W'(WIDTH - 1);
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_vld_q <= gnt_vld_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_vld = gnt_vld_q;
   assign bus.gnt_idx = idx_q;
endmodule
